// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - run-time fabric clock divider with glitch-free divisor updates
// Divisor changes and stop requests only take effect at a period boundary (wrap).
module clkdiv_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             busy,
    output logic [CNT_W-1:0] div_active
);

    localparam int               RESET_DIV_I = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [CNT_W-1:0] RESET_DIV   = RESET_DIV_I[CNT_W-1:0];

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;

    logic             fire;
    logic             wrap;
    logic [CNT_W-1:0] div_half;
    logic [CNT_W-1:0] div_last;

    // Divisors below 2 cannot produce a clock, so they are raised to 2.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    assign div_ready  = (state_q != PEND);
    assign busy       = (state_q != STOP);
    assign clk_out    = clk_q;
    assign rise_tick  = rise_q;
    assign div_active = div_q;

    assign fire     = div_valid && div_ready;
    assign div_half = div_q >> 1;
    assign div_last = div_q - CNT_W'(1);
    assign wrap     = (state_q != STOP) && (cnt_q == div_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        clk_d   = 1'b0;
        rise_d  = 1'b0;
        case (state_q)
            STOP: begin
                cnt_d = '0;
                if (fire) div_d = clamp_div(div_in);
                if (enable) state_d = RUN;
            end
            RUN, PEND: begin
                clk_d  = (cnt_q < div_half);
                rise_d = (cnt_q == '0);
                cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
                if ((state_q == RUN) && fire) begin
                    pend_d  = clamp_div(div_in);
                    state_d = PEND;
                end
                if (wrap) begin
                    if (state_q == PEND) div_d = pend_q;
                    if (!enable) begin
                        state_d = STOP;
                        // A divisor accepted on the stopping edge is applied directly.
                        if ((state_q == RUN) && fire) div_d = clamp_div(div_in);
                    end else if (state_q == PEND) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = STOP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOP;
            cnt_q   <= '0;
            div_q   <= RESET_DIV;
            pend_q  <= '0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
        end
    end

endmodule
